// File: rtl/fifo_array_skewed.sv
`default_nettype none
// ============================================================================
// Module   : fifo_array_skewed
// Purpose  : Bank of NUM_LANES lock-step FIFOs feeding one edge of a systolic
//            array. All lanes are written together. Reads are either
//            lock-step or diagonally skewed (lane i reads i cycles after
//            lane 0). A read rewind (rd_clr) replays the stored words.
// Option   : FIFO_ARRAY_SKEW_EN - when defined, a NUM_LANES-1 stage shift
//            register of rd_en produces the per-lane read strobes. When it
//            is undefined, all lanes read in lock-step.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            wr_clr            - clear all pointers and the sticky flags
//            rd_clr            - rewind the read pointers (replay)
//            wr_en, data_in    - write one word into every lane
//            rd_en             - read request
//            data_out,valid_out- registered read data and per-lane valid
//            empty,full,count  - per-lane status, decoded from the pointers
//            overflow          - sticky flag: a write was dropped
//            underflow         - sticky flag: a read strobe hit an empty lane
// Revision : 1.0 - initial release
// ============================================================================
module fifo_array_skewed #(
  parameter int DATA_WIDTH     = 8,
  parameter int ELEMS_PER_LANE = 2,
  parameter int NUM_LANES      = 8,
  parameter int DEPTH          = 16
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             wr_clr,
  input  logic                                             rd_clr,
  input  logic                                             wr_en,
  input  logic                                             rd_en,
  input  logic [NUM_LANES*DATA_WIDTH*ELEMS_PER_LANE-1:0]   data_in,
  output logic [NUM_LANES*DATA_WIDTH*ELEMS_PER_LANE-1:0]   data_out,
  output logic [NUM_LANES-1:0]                             valid_out,
  output logic [NUM_LANES-1:0]                             empty,
  output logic [NUM_LANES-1:0]                             full,
  output logic [NUM_LANES*($clog2(DEPTH)+1)-1:0]           count,
  output logic                                             overflow,
  output logic                                             underflow
);

  localparam int LANE_W     = DATA_WIDTH * ELEMS_PER_LANE;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PTR_W      = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);

  // All lanes are always written together, so one write pointer serves them.
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q [NUM_LANES];
  logic [PTR_W-1:0]              rd_ptr_d [NUM_LANES];
  logic [LANE_W-1:0]             mem_q    [NUM_LANES][DEPTH];
  logic [NUM_LANES*LANE_W-1:0]   data_out_q, data_out_d;
  logic [NUM_LANES-1:0]          valid_q, valid_d;
  logic                          overflow_q, overflow_d;
  logic                          underflow_q, underflow_d;

  logic [PTR_W-1:0]              cnt_w [NUM_LANES];
  logic [NUM_LANES-1:0]          empty_w;
  logic [NUM_LANES-1:0]          full_w;
  logic [NUM_LANES-1:0]          rs_w;
  logic [NUM_LANES-1:0]          rd_fire_w;
  logic                          clr_any_w;
  logic                          rd_req_w;
  logic                          wr_acc_w;

  // --------------------------------------------------------------------------
  // Status decode from registered pointers
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_status
      assign cnt_w[i]                    = wr_ptr_q - rd_ptr_q[i];
      assign empty_w[i]                  = (cnt_w[i] == '0);
      assign full_w[i]                   = (cnt_w[i] == C_DEPTH);
      assign count[i*PTR_W +: PTR_W]     = cnt_w[i];
    end
  endgenerate

  // Either clear suppresses the read request sampled in the same cycle.
  assign clr_any_w = wr_clr | rd_clr;
  assign rd_req_w  = rd_en & ~clr_any_w;

  // A write is dropped when any lane is full, even if that lane is being read.
  assign wr_acc_w  = wr_en & ~wr_clr & ~(|full_w);

  // --------------------------------------------------------------------------
  // Per-lane read strobes
  // --------------------------------------------------------------------------
`ifdef FIFO_ARRAY_SKEW_EN
  generate
    if (NUM_LANES > 1) begin : g_skew
      // skew_q[k] holds the read request sampled k+1 edges ago.
      logic [NUM_LANES-2:0] skew_q, skew_d;

      always_comb begin
        skew_d = '0;
        if (!clr_any_w) begin
          skew_d[0] = rd_req_w;
          for (int k = 1; k < NUM_LANES - 1; k++) begin
            skew_d[k] = skew_q[k-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          skew_q <= '0;
        end else begin
          skew_q <= skew_d;
        end
      end

      // Strobes already in flight are dropped by either clear.
      assign rs_w = clr_any_w ? '0 : {skew_q, rd_req_w};
    end else begin : g_skew_single
      assign rs_w = rd_req_w;
    end
  endgenerate
`else
  assign rs_w = {NUM_LANES{rd_req_w}};
`endif

  assign rd_fire_w = rs_w & ~empty_w;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    data_out_d  = data_out_q;
    valid_d     = '0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
    end

    if (wr_clr) begin
      wr_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr_d[i] = '0;
      end
    end else begin
      if (wr_acc_w) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (wr_en && (|full_w)) begin
        overflow_d = 1'b1;
      end
      if (|(rs_w & empty_w)) begin
        underflow_d = 1'b1;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (rd_clr) begin
          rd_ptr_d[i] = '0;
        end else if (rd_fire_w[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
          data_out_d[i*LANE_W +: LANE_W] = mem_q[i][rd_ptr_q[i][ADDR_WIDTH-1:0]];
        end
      end
      valid_d = rd_fire_w;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      data_out_q  <= '0;
      valid_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Storage is never reset so that it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc_w) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        mem_q[i][wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in[i*LANE_W +: LANE_W];
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire
